// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared state encoding and sizing constants for the signed divider
package divider_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_WIDTH = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter must hold WIDTH-1; guard the degenerate 1-bit case.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/divider_div_step.sv
// rtl/divider_div_step.sv - one unsigned restoring division iteration
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quot_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  // rem < divisor always holds, so the shifted value stays below 2^WIDTH and
  // the top bit of the difference is a clean borrow flag.
  assign shifted   = {rem, quot[WIDTH-1]};
  assign diff      = shifted - {1'b0, divisor};
  assign fits      = ~diff[WIDTH];
  assign rem_next  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quot_next = {quot[WIDTH-2:0], fits};

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - multi-cycle signed divider: sign fold, WIDTH restoring steps, sign fix
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] operando1,
  input  logic [WIDTH-1:0] operando2,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             fim,
  output logic             div0
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quot, divisor;
  logic [WIDTH-1:0] rem_next, quot_next;
  logic [WIDTH-1:0] mag1, mag2;
  logic             sign1, sign2;
  logic             zero_div;

  assign mag1     = operando1[WIDTH-1] ? -operando1 : operando1;
  assign mag2     = operando2[WIDTH-1] ? -operando2 : operando2;
  assign zero_div = (operando2 == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem       (rem),
    .quot      (quot),
    .divisor   (divisor),
    .rem_next  (rem_next),
    .quot_next (quot_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    fim        = 1'b0;
    case (state)
      IDLE, DONE: begin
        fim = 1'b1;
        if (start) state_next = zero_div ? DONE : CALC;
      end
      CALC:    if (cnt == '0) state_next = FIX;
      FIX:     state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      div0    <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
      sign1   <= 1'b0;
      sign2   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start && zero_div) begin
            hi   <= operando1;
            lo   <= '1;
            div0 <= 1'b1;
          end else if (start) begin
            rem     <= '0;
            quot    <= mag1;
            divisor <= mag2;
            sign1   <= operando1[WIDTH-1];
            sign2   <= operando2[WIDTH-1];
            cnt     <= CW'(WIDTH - 1);
            div0    <= 1'b0;
          end
        end
        CALC: begin
          rem  <= rem_next;
          quot <= quot_next;
          cnt  <= cnt - 1'b1;
        end
        FIX: begin
          // Quotient truncates toward zero; remainder follows the dividend.
          lo <= (sign1 ^ sign2) ? -quot : quot;
          hi <= sign1 ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - randomized self-checking bench for divider against an arithmetic model
module tb_divider;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] operando1, operando2;
  logic [W-1:0] hi, lo;
  logic         fim, div0;

  int checks   = 0;
  int failures = 0;

  divider #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .operando1 (operando1),
    .operando2 (operando2),
    .hi        (hi),
    .lo        (lo),
    .fim       (fim),
    .div0      (div0)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    int signed sa, sb;
    sa = a;
    sb = b;
    z  = (sb == 0);
    if (z) begin
      q = '1;
      r = a;
    end else if (sa == 32'sh8000_0000 && sb == -1) begin
      q = a;
      r = '0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  task automatic wait_done(input string tag, output int n, output bit held);
    logic [W-1:0] h0, l0;
    h0   = hi;
    l0   = lo;
    held = 1'b1;
    n    = 0;
    while (!fim && n < 100) begin
      if (hi !== h0 || lo !== l0) held = 1'b0;
      @(posedge clock); #1;
      n++;
    end
    check({tag, "_latency"}, n, LAT);
    check({tag, "_hold"}, held, 1'b1);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    logic         ez;
    ref_div(a, b, eq, er, ez);
    check({tag, "_lo"}, lo, eq);
    check({tag, "_hi"}, hi, er);
    check({tag, "_div0"}, div0, ez);
    check({tag, "_fim"}, fim, 1'b1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    bit held;
    @(negedge clock);
    start = 1'b1; operando1 = a; operando2 = b;
    @(posedge clock); #1;
    start = 1'b0; operando1 = $urandom; operando2 = $urandom;
    if (b == '0) begin
      check_result(tag, a, b);
    end else begin
      check({tag, "_busy"}, fim, 1'b0);
      wait_done(tag, n, held);
      check_result(tag, a, b);
    end
  endtask

  initial begin
    int n;
    bit held;
    logic [W-1:0] a, b;
    reset = 1'b1; start = 1'b0; operando1 = '0; operando2 = '0;
    #1;
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_fim", fim, 1'b1);
    check("rst_div0", div0, 1'b0);
    @(posedge clock); #2;
    reset = 1'b0;

    run_op("p100_7", 32'd100, 32'd7);
    run_op("n100_7", -32'sd100, 32'd7);
    run_op("p100_n7", 32'd100, -32'sd7);
    run_op("n100_n7", -32'sd100, -32'sd7);
    run_op("minint_m1", 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("zero55", 32'd55, 32'd0);
    run_op("after_zero", 32'd7, 32'd100);
    run_op("minint_1", 32'h8000_0000, 32'd1);

    // Reset in the middle of a calculation.
    @(negedge clock);
    start = 1'b1; operando1 = 32'd100; operando2 = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("midrst_hi", hi, '0);
    check("midrst_lo", lo, '0);
    check("midrst_fim", fim, 1'b1);
    @(posedge clock); #2;
    reset = 1'b0;
    run_op("post_rst", 32'd9, 32'd3);

    // Start held high: changed operands during CALC are ignored, then accepted back-to-back.
    a = 32'd1000;
    b = -32'sd37;
    @(negedge clock);
    start = 1'b1; operando1 = a; operando2 = 32'd13;
    @(posedge clock); #1;
    operando1 = b; operando2 = 32'd5;
    check("hold_busy", fim, 1'b0);
    wait_done("hold_first", n, held);
    check_result("hold_first", a, 32'd13);
    @(posedge clock); #1;
    start = 1'b0;
    check("hold_accept", fim, 1'b0);
    wait_done("hold_second", n, held);
    check_result("hold_second", b, 32'd5);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 20);
        2:       b = -$urandom_range(1, 20);
        3:       b = '0;
        default: begin a = $urandom_range(0, 50) - 25; b = $urandom_range(0, 12) - 6; end
      endcase
      run_op($sformatf("rnd%0d", i), a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
